module_subroutine_split: RTL and testbench

Sequential receiver for the saturated-sum/parity result pair produced by the add-and-check-even subroutine stage. It accepts one `{sum, is_even}` word per valid/ready transfer and clamps the sum to the saturation limit. It checks the parity flag against the clamped value, then splits the sum back into two near-equal operands with an iterative halving loop that exits early. It sits downstream of the subroutine datapath in the LoopStatements test set and drives a valid/ready result port.

---
 rtl/module_subroutine_split_pkg.sv | 32 +++
 rtl/module_subroutine_split_if.sv | 24 ++
 rtl/module_subroutine_split_halver.sv | 51 +++++
 rtl/module_subroutine_split.sv | 99 +++++++++
 tb/tb_module_subroutine_split.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/module_subroutine_split_pkg.sv
// Shared types for the saturated-sum receiver: FSM states, flag bundle, clamp helper.
package module_subroutine_split_pkg;

  localparam int SAT_LIMIT_DEFAULT = 100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SPLIT = 2'd2,
    S_DONE  = 2'd3
  } split_state_e;

  typedef struct packed {
    logic sat;
    logic par_err;
    logic neg_err;
  } split_flags_t;

  // Negative sums clamp to zero here; the caller reports them separately.
  function automatic logic [31:0] clamp_sum(input logic signed [31:0] sum, input int limit);
    logic [31:0] res;
    if (sum < 32'sd0) begin
      res = 32'd0;
    end else if (sum > limit) begin
      res = 32'(limit);
    end else begin
      res = 32'(sum);
    end
    return res;
  endfunction

endpackage

// File: rtl/module_subroutine_split_if.sv
// Valid/ready word input and result port of the saturated-sum receiver.
interface module_subroutine_split_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_sum;
  logic               in_is_even;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_a;
  logic [31:0]        out_b;
  logic               out_sat;
  logic               out_par_err;
  logic               out_neg_err;

  modport slave (
    input  in_valid, in_sum, in_is_even, out_ready,
    output in_ready, out_valid, out_a, out_b, out_sat, out_par_err, out_neg_err
  );

  modport master (
    output in_valid, in_sum, in_is_even, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_sat, out_par_err, out_neg_err
  );
endinterface

// File: rtl/module_subroutine_split_halver.sv
// Splits a clamped sum into half/remainder; iterative by default, single-cycle
// when MODULE_SUBROUTINE_SPLIT_FAST_EN is defined.
module subroutine_halver #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] rem_in,
  output logic         done,
  output logic [W-1:0] half_out,
  output logic [W-1:0] rem_out
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic         r_busy;
  logic [W-1:0] r_rem;
  logic [W-1:0] r_half;

  // Busy clears on the exit edge, so done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_half <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
`ifdef MODULE_SUBROUTINE_SPLIT_FAST_EN
      r_rem  <= rem_in & ONE;
      r_half <= rem_in >> 1;
`else
      r_rem  <= rem_in;
      r_half <= '0;
`endif
    end else if (r_busy) begin
      if (r_rem < TWO) begin
        r_busy <= 1'b0;
      end else begin
        r_rem  <= r_rem - TWO;
        r_half <= r_half + ONE;
      end
    end
  end

  assign done     = r_busy && (r_rem < TWO);
  assign half_out = r_half;
  assign rem_out  = r_rem;

endmodule

// File: rtl/module_subroutine_split.sv
// Receiver FSM: clamp, parity check and near-equal split of {sum, is_even} words.
// Build option: MODULE_SUBROUTINE_SPLIT_FAST_EN selects the one-cycle halver.
module module_subroutine_split
  import module_subroutine_split_pkg::*;
#(
  parameter int SAT_LIMIT = SAT_LIMIT_DEFAULT
) (
  input logic clk,
  input logic rst,
  module_subroutine_split_if.slave bus
);

  localparam int W = $clog2(SAT_LIMIT + 1);

  split_state_e       r_state, w_next;
  logic signed [31:0] r_sum;
  logic               r_is_even;
  split_flags_t       r_flags;
  split_flags_t       r_out_flags;
  logic [31:0]        r_out_a, r_out_b;
  logic [31:0]        w_clamped;
  logic [W-1:0]       w_rem_in, w_half, w_rem;
  logic               w_neg, w_start, w_done;

  assign w_neg     = (r_sum < 32'sd0);
  assign w_clamped = clamp_sum(r_sum, SAT_LIMIT);
  assign w_rem_in  = w_clamped[W-1:0];

  subroutine_halver #(.W(W)) u_halver (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .rem_in   (w_rem_in),
    .done     (w_done),
    .half_out (w_half),
    .rem_out  (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.in_valid  ? S_CHECK : S_IDLE;
      S_CHECK: w_next = w_neg         ? S_DONE  : S_SPLIT;
      S_SPLIT: w_next = w_done        ? S_DONE  : S_SPLIT;
      S_DONE:  w_next = bus.out_ready ? S_IDLE  : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    w_start       = (r_state == S_CHECK) && !w_neg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum     <= 32'sd0;
      r_is_even <= 1'b0;
      r_flags   <= '0;
    end else if (r_state == S_IDLE && bus.in_valid) begin
      r_sum     <= bus.in_sum;
      r_is_even <= bus.in_is_even;
    end else if (r_state == S_CHECK) begin
      r_flags.sat     <= (w_clamped == 32'(SAT_LIMIT));
      r_flags.par_err <= ((w_rem_in[0] == 1'b0) != r_is_even);
      r_flags.neg_err <= 1'b0;
    end
  end

  // Result registers change only on entry to DONE, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_a     <= 32'd0;
      r_out_b     <= 32'd0;
      r_out_flags <= '0;
    end else if (r_state == S_CHECK && w_neg) begin
      r_out_a     <= 32'd0;
      r_out_b     <= 32'd0;
      r_out_flags <= '{sat: 1'b0, par_err: 1'b0, neg_err: 1'b1};
    end else if (r_state == S_SPLIT && w_done) begin
      r_out_a     <= 32'(w_half) + 32'(w_rem);
      r_out_b     <= 32'(w_half);
      r_out_flags <= r_flags;
    end
  end

  assign bus.out_a       = r_out_a;
  assign bus.out_b       = r_out_b;
  assign bus.out_sat     = r_out_flags.sat;
  assign bus.out_par_err = r_out_flags.par_err;
  assign bus.out_neg_err = r_out_flags.neg_err;

endmodule

// File: tb/tb_module_subroutine_split.sv
// Directed bench for module_subroutine_split with hand-computed results and latencies.
module tb_module_subroutine_split;

`ifdef MODULE_SUBROUTINE_SPLIT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  module_subroutine_split_if bus ();

  module_subroutine_split #(.SAT_LIMIT(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a word, wait for the accept edge, then count edges until out_valid.
  task automatic send_word(input logic signed [31:0] sum, input logic even, output int lat);
    bus.in_sum     = sum;
    bus.in_is_even = even;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 999;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic accept_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'sd10;
    bus.in_is_even = 1'b1;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.out_a !== 32'd0 || bus.out_b !== 32'd0 || bus.out_sat !== 1'b0 ||
        bus.out_par_err !== 1'b0 || bus.out_neg_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: a=%0d b=%0d sat=%b par=%b neg=%b want all 0",
               bus.out_a, bus.out_b, bus.out_sat, bus.out_par_err, bus.out_neg_err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_accept: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_split_odd();
    int lat;
    send_word(32'sd37, 1'b0, lat);
    checks++;
    if (lat !== (FAST ? 2 : 20)) begin
      failures++;
      $display("FAIL odd_latency: got %0d want %0d", lat, FAST ? 2 : 20);
    end
    checks++;
    if (bus.out_a !== 32'd19 || bus.out_b !== 32'd18 || bus.out_sat !== 1'b0 ||
        bus.out_par_err !== 1'b0 || bus.out_neg_err !== 1'b0) begin
      failures++;
      $display("FAIL odd_result: a=%0d b=%0d sat=%b par=%b neg=%b want 19 18 0 0 0",
               bus.out_a, bus.out_b, bus.out_sat, bus.out_par_err, bus.out_neg_err);
    end
    accept_result();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL odd_return_idle: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    int lat;
    send_word(32'sd250, 1'b1, lat);
    checks++;
    if (lat !== (FAST ? 2 : 52)) begin
      failures++;
      $display("FAIL sat_latency: got %0d want %0d", lat, FAST ? 2 : 52);
    end
    checks++;
    if (bus.out_a !== 32'd50 || bus.out_b !== 32'd50 || bus.out_sat !== 1'b1 ||
        bus.out_par_err !== 1'b0 || bus.out_neg_err !== 1'b0) begin
      failures++;
      $display("FAIL sat_result: a=%0d b=%0d sat=%b par=%b neg=%b want 50 50 1 0 0",
               bus.out_a, bus.out_b, bus.out_sat, bus.out_par_err, bus.out_neg_err);
    end
    accept_result();
    send_word(32'sh7FFFFFFF, 1'b0, lat);
    checks++;
    if (lat !== (FAST ? 2 : 52) || bus.out_a !== 32'd50 || bus.out_b !== 32'd50 ||
        bus.out_sat !== 1'b1 || bus.out_par_err !== 1'b1) begin
      failures++;
      $display("FAIL intmax_result: lat=%0d a=%0d b=%0d sat=%b par=%b want %0d 50 50 1 1",
               lat, bus.out_a, bus.out_b, bus.out_sat, bus.out_par_err, FAST ? 2 : 52);
    end
    accept_result();
  endtask

  task automatic test_negative();
    int lat;
    send_word(-32'sd5, 1'b0, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL neg_latency: got %0d want 1", lat);
    end
    checks++;
    if (bus.out_a !== 32'd0 || bus.out_b !== 32'd0 || bus.out_sat !== 1'b0 ||
        bus.out_par_err !== 1'b0 || bus.out_neg_err !== 1'b1) begin
      failures++;
      $display("FAIL neg_result: a=%0d b=%0d sat=%b par=%b neg=%b want 0 0 0 0 1",
               bus.out_a, bus.out_b, bus.out_sat, bus.out_par_err, bus.out_neg_err);
    end
    accept_result();
  endtask

  task automatic test_zero();
    int lat;
    send_word(32'sd0, 1'b1, lat);
    checks++;
    if (lat !== 2 || bus.out_a !== 32'd0 || bus.out_b !== 32'd0 ||
        bus.out_par_err !== 1'b0 || bus.out_neg_err !== 1'b0) begin
      failures++;
      $display("FAIL zero_result: lat=%0d a=%0d b=%0d par=%b neg=%b want 2 0 0 0 0",
               lat, bus.out_a, bus.out_b, bus.out_par_err, bus.out_neg_err);
    end
    accept_result();
  endtask

  task automatic test_backpressure();
    int lat;
    send_word(32'sd4, 1'b0, lat);
    checks++;
    if (lat !== (FAST ? 2 : 4)) begin
      failures++;
      $display("FAIL bp_latency: got %0d want %0d", lat, FAST ? 2 : 4);
    end
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'sd77;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_a !== 32'd2 ||
          bus.out_b !== 32'd2 || bus.out_par_err !== 1'b1 || bus.out_sat !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b a=%0d b=%0d par=%b sat=%b want 1 0 2 2 1 0",
                 c, bus.out_valid, bus.in_ready, bus.out_a, bus.out_b, bus.out_par_err, bus.out_sat);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    accept_result();
  endtask

  task automatic test_reset_mid_split();
    int lat;
    bus.in_sum     = 32'sd90;
    bus.in_is_even = 1'b1;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat ((FAST ? 1 : 5)) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_a !== 32'd0 ||
        bus.out_b !== 32'd0 || bus.out_par_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: ready=%b valid=%b a=%0d b=%0d par=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_par_err);
    end
    send_word(32'sd1, 1'b0, lat);
    checks++;
    if (lat !== 2 || bus.out_a !== 32'd1 || bus.out_b !== 32'd0 ||
        bus.out_par_err !== 1'b0 || bus.out_sat !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_one: lat=%0d a=%0d b=%0d par=%b sat=%b want 2 1 0 0 0",
               lat, bus.out_a, bus.out_b, bus.out_par_err, bus.out_sat);
    end
    accept_result();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_split_odd();
    test_saturate();
    test_negative();
    test_zero();
    test_backpressure();
    test_reset_mid_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
